pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central hazard/flush controller for the 5-stage pipeline.
- Collects stall requests from ID, EX and MEM, branch redirects from EX, and exceptions from MEM.
- Drives per-register pause and flush lines into PC, if_id, id_ex, ex_mem and mem_wb, plus the PC redirect.
- Holds a branch redirect that resolves during a downstream stall, and runs a stall watchdog.

Parameters:
- ADDR_W, 16, instruction address width (matches InstAddrBus).
- EXC_VECTOR, 16'h0004, PC loaded on exception.
- MAX_STALL, 255, consecutive stall cycles before hang_o asserts.
- CNT_W, 8, stall counter width; must satisfy 2^CNT_W > MAX_STALL.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- stallreq_id_i  in  1  load-use hazard in ID.
- stallreq_ex_i  in  1  multi-cycle EX op busy.
- stallreq_mem_i  in  1  data memory wait.
- branch_i  in  1  EX resolved a taken branch / mispredict.
- branch_target_i  in  ADDR_W  branch target.
- exc_i  in  1  exception raised in MEM.
- pause_o  out  5  bit0 PC, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb.
- flush_o  out  5  same bit mapping; flush bit forces a bubble.
- redirect_o  out  1  load new_pc_o into PC this cycle.
- new_pc_o  out  ADDR_W  redirect address.
- hang_o  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst==0, asynchronous):
  - state=RUN, pending target=0, counter=0, hang_o=0.
  - All combinational outputs evaluate to 0 with inputs idle.
- pause_o, flush_o, redirect_o and new_pc_o are combinational from inputs and state, giving zero-cycle response. State, pending target, counter and hang_o are registers.
- Priority, highest first:
  1. exc_i: pause_o=0; flush_o=5'b01110; redirect to EXC_VECTOR; pending branch discarded; next state RUN. Overrides all stalls.
  2. stallreq_mem_i: pause_o=5'b01111, flush_o=5'b10000.
  3. stallreq_ex_i: pause_o=5'b00111, flush_o=5'b01000.
  4. branch redirect (new branch_i, or pending from BR_PEND): flush_o=5'b00110, redirect_o=1, new_pc_o=target.
  5. stallreq_id_i: pause_o=5'b00011, flush_o=5'b00100.
- Branch during a stall: if branch_i=1 while stallreq_mem_i or stallreq_ex_i is 1:
  - no redirect that cycle;
  - branch_target_i latched; state RUN->BR_PEND.
- BR_PEND state:
  - branch_i is ignored.
  - On the first cycle with no exc_i and no mem/ex stall, the redirect issues from the latched target; next state RUN.
  - A stallreq_id_i in that same cycle is suppressed, because the flush removes the offending instruction.
- A branch coinciding with a stallreq_id_i only (no mem/ex stall) redirects immediately and suppresses the ID stall.
- Watchdog:
  - Counter increments on every cycle with any nonzero pause_o bit; clears on any cycle with pause_o==0.
  - Counter saturates; it never wraps.
  - When counter reaches MAX_STALL, hang_o<=1 and stays 1 until reset.
  - hang_o does not alter pipeline control.
- Reset mid-stall or in BR_PEND: pending target discarded; returns to RUN.

Decomposition:
- Shared defines header:
  - stage-bit indices (PC/IF_ID/ID_EX/EX_MEM/MEM_WB);
  - state encodings RUN=1'b0, BR_PEND=1'b1;
  - the five pause/flush pattern constants above.
- Optional sub-module pipe_stall_wdog (saturating counter plus sticky flag), so the watchdog can be unit-tested apart.

Test Plan:
1. Reset then idle: rst low 3 cycles, release -> pause_o=0, flush_o=0, redirect_o=0, hang_o=0.
2. Load-use: stallreq_id_i=1 for 1 cycle -> pause_o=5'b00011, flush_o=5'b00100 that cycle, 0 after.
3. Branch during MEM stall: stallreq_mem_i=1 for cycles 0-2, branch_i=1 with target 16'h0040 at cycle 1 -> no redirect in cycles 1-2; cycle 3: redirect_o=1, new_pc_o=16'h0040, flush_o=5'b00110; cycle 4 all 0.
4. Exception kills pending branch: enter BR_PEND with target 16'h0080, then exc_i=1 while stallreq_ex_i=1 -> redirect to 16'h0004, flush_o=5'b01110, pause_o=0; no later redirect to 16'h0080.
5. Watchdog: MAX_STALL=4, hold stallreq_ex_i for 6 cycles -> hang_o rises after the 4th stalled cycle and stays 1 after the stall drops; only rst clears it.
6. Async reset in BR_PEND: assert rst mid-cycle -> state RUN immediately; after release, no redirect occurs.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared stage indices, FSM encoding and pause/flush patterns for the
// pipeline hazard/flush controller.
package pipe_ctrl_pkg;

   localparam int unsigned NSTAGE = 5;

   localparam int unsigned STG_PC     = 0;
   localparam int unsigned STG_IF_ID  = 1;
   localparam int unsigned STG_ID_EX  = 2;
   localparam int unsigned STG_EX_MEM = 3;
   localparam int unsigned STG_MEM_WB = 4;

   typedef logic [NSTAGE-1:0] stage_vec_t;

   typedef enum logic {
      RUN     = 1'b0,
      BR_PEND = 1'b1
   } state_e;

   // Per-cycle control word driven into the pipeline registers
   typedef struct packed {
      stage_vec_t pause;
      stage_vec_t flush;
   } pipe_ctl_t;

   localparam stage_vec_t B_PC     = stage_vec_t'(1) << STG_PC;
   localparam stage_vec_t B_IF_ID  = stage_vec_t'(1) << STG_IF_ID;
   localparam stage_vec_t B_ID_EX  = stage_vec_t'(1) << STG_ID_EX;
   localparam stage_vec_t B_EX_MEM = stage_vec_t'(1) << STG_EX_MEM;
   localparam stage_vec_t B_MEM_WB = stage_vec_t'(1) << STG_MEM_WB;

   localparam stage_vec_t PAUSE_MEM = B_PC | B_IF_ID | B_ID_EX | B_EX_MEM; // 01111
   localparam stage_vec_t FLUSH_MEM = B_MEM_WB;                            // 10000
   localparam stage_vec_t PAUSE_EX  = B_PC | B_IF_ID | B_ID_EX;            // 00111
   localparam stage_vec_t FLUSH_EX  = B_EX_MEM;                            // 01000
   localparam stage_vec_t FLUSH_BR  = B_IF_ID | B_ID_EX;                   // 00110
   localparam stage_vec_t PAUSE_ID  = B_PC | B_IF_ID;                      // 00011
   localparam stage_vec_t FLUSH_ID  = B_ID_EX;                             // 00100
   localparam stage_vec_t FLUSH_EXC = B_IF_ID | B_ID_EX | B_EX_MEM;        // 01110

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Stall watchdog: saturating count of consecutive paused cycles and a
// sticky hang flag that only reset clears.
module pipe_stall_wdog #(
   parameter int unsigned MAX_STALL = 255,
   parameter int unsigned CNT_W     = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic stall_i,
   output logic hang_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_STALL);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hang_q, hang_d;

   always_comb begin
      cnt_d  = '0;
      hang_d = hang_q;
      if (stall_i) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end
      if (cnt_d >= LIMIT) begin
         hang_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         hang_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         hang_q <= hang_d;
      end
   end

   assign hang_o = hang_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard/flush controller: arbitrates stalls, branch redirects and
// exceptions into per-stage pause/flush lines with zero-cycle response.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(16'h0004),
   parameter int unsigned       MAX_STALL  = 255,
   parameter int unsigned       CNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_id_i,
   input  logic              stallreq_ex_i,
   input  logic              stallreq_mem_i,
   input  logic              branch_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   input  logic              exc_i,
   output logic [NSTAGE-1:0] pause_o,
   output logic [NSTAGE-1:0] flush_o,
   output logic              redirect_o,
   output logic [ADDR_W-1:0] new_pc_o,
   output logic              hang_o
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pend_q, pend_d;
   pipe_ctl_t         ctl;
   logic              redirect;
   logic [ADDR_W-1:0] new_pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   // Priority: exception > MEM stall > EX stall > redirect > ID stall
   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      ctl      = '0;
      redirect = 1'b0;
      new_pc   = '0;

      if (exc_i) begin
         ctl.flush = FLUSH_EXC;
         redirect  = 1'b1;
         new_pc    = EXC_VECTOR;
         state_d   = RUN;
         pend_d    = '0;
      end else if (stallreq_mem_i || stallreq_ex_i) begin
         if (stallreq_mem_i) begin
            ctl.pause = PAUSE_MEM;
            ctl.flush = FLUSH_MEM;
         end else begin
            ctl.pause = PAUSE_EX;
            ctl.flush = FLUSH_EX;
         end
         // A branch resolved under a stall waits for the stall to clear
         if (state_q == RUN && branch_i) begin
            pend_d  = branch_target_i;
            state_d = BR_PEND;
         end
      end else if (state_q == BR_PEND) begin
         ctl.flush = FLUSH_BR;
         redirect  = 1'b1;
         new_pc    = pend_q;
         state_d   = RUN;
         pend_d    = '0;
      end else if (branch_i) begin
         ctl.flush = FLUSH_BR;
         redirect  = 1'b1;
         new_pc    = branch_target_i;
      end else if (stallreq_id_i) begin
         ctl.pause = PAUSE_ID;
         ctl.flush = FLUSH_ID;
      end
   end

   assign pause_o    = ctl.pause;
   assign flush_o    = ctl.flush;
   assign redirect_o = redirect;
   assign new_pc_o   = new_pc;

   pipe_stall_wdog #(
      .MAX_STALL (MAX_STALL),
      .CNT_W     (CNT_W)
   ) u_wdog (
      .clk     (clk),
      .rst_n   (rst),
      .stall_i (|ctl.pause),
      .hang_o  (hang_o)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl, built with a 4-cycle stall limit.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stallreq_id_i = 1'b0;
   logic        stallreq_ex_i = 1'b0;
   logic        stallreq_mem_i = 1'b0;
   logic        branch_i = 1'b0;
   logic [15:0] branch_target_i = '0;
   logic        exc_i = 1'b0;
   logic [4:0]  pause_o;
   logic [4:0]  flush_o;
   logic        redirect_o;
   logic [15:0] new_pc_o;
   logic        hang_o;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(
      .ADDR_W     (16),
      .EXC_VECTOR (16'h0004),
      .MAX_STALL  (4),
      .CNT_W      (3)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stallreq_id_i   (stallreq_id_i),
      .stallreq_ex_i   (stallreq_ex_i),
      .stallreq_mem_i  (stallreq_mem_i),
      .branch_i        (branch_i),
      .branch_target_i (branch_target_i),
      .exc_i           (exc_i),
      .pause_o         (pause_o),
      .flush_o         (flush_o),
      .redirect_o      (redirect_o),
      .new_pc_o        (new_pc_o),
      .hang_o          (hang_o)
   );

   // Apply one cycle of inputs at the falling edge and let outputs settle
   task automatic drive(input logic id, input logic ex, input logic mem,
                        input logic br, input logic [15:0] tgt, input logic exc);
      @(negedge clk);
      stallreq_id_i   = id;
      stallreq_ex_i   = ex;
      stallreq_mem_i  = mem;
      branch_i        = br;
      branch_target_i = tgt;
      exc_i           = exc;
      #1;
   endtask

   task automatic test_reset;
      logic [27:0] obs;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, 0, 16'h0000, 0);
      obs = {pause_o, flush_o, redirect_o, new_pc_o, hang_o};
      chk_cnt++;
      if (obs !== 28'h0) $display("FAIL reset_idle got=%h exp=%h", obs, 28'h0);
      else pass_cnt++;
   endtask

   task automatic test_load_use;
      logic [26:0] obs;
      drive(1, 0, 0, 0, 16'h0000, 0);
      obs = {pause_o, flush_o, redirect_o, new_pc_o};
      chk_cnt++;
      if (obs !== {5'b00011, 5'b00100, 1'b0, 16'h0000})
         $display("FAIL load_use got=%h exp=%h", obs, {5'b00011, 5'b00100, 1'b0, 16'h0000});
      else pass_cnt++;
      drive(0, 0, 0, 0, 16'h0000, 0);
      obs = {pause_o, flush_o, redirect_o, new_pc_o};
      chk_cnt++;
      if (obs !== 27'h0) $display("FAIL load_use_after got=%h exp=%h", obs, 27'h0);
      else pass_cnt++;
   endtask

   task automatic test_branch_mem_stall;
      logic [26:0] obs;
      logic [26:0] exp_v [5];
      logic        mem_v [5];
      logic        br_v  [5];
      exp_v[0] = {5'b01111, 5'b10000, 1'b0, 16'h0000}; mem_v[0] = 1; br_v[0] = 0;
      exp_v[1] = {5'b01111, 5'b10000, 1'b0, 16'h0000}; mem_v[1] = 1; br_v[1] = 1;
      exp_v[2] = {5'b01111, 5'b10000, 1'b0, 16'h0000}; mem_v[2] = 1; br_v[2] = 0;
      exp_v[3] = {5'b00000, 5'b00110, 1'b1, 16'h0040}; mem_v[3] = 0; br_v[3] = 0;
      exp_v[4] = 27'h0;                                mem_v[4] = 0; br_v[4] = 0;
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, mem_v[i], br_v[i], br_v[i] ? 16'h0040 : 16'h0000, 0);
         obs = {pause_o, flush_o, redirect_o, new_pc_o};
         chk_cnt++;
         if (obs !== exp_v[i]) $display("FAIL br_mem_c%0d got=%h exp=%h", i, obs, exp_v[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_exc_kills_pending;
      logic [26:0] obs;
      drive(0, 1, 0, 1, 16'h0080, 0);
      drive(0, 1, 0, 0, 16'h0000, 1);
      obs = {pause_o, flush_o, redirect_o, new_pc_o};
      chk_cnt++;
      if (obs !== {5'b00000, 5'b01110, 1'b1, 16'h0004})
         $display("FAIL exc_redirect got=%h exp=%h", obs, {5'b00000, 5'b01110, 1'b1, 16'h0004});
      else pass_cnt++;
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 0, 16'h0000, 0);
         obs = {pause_o, flush_o, redirect_o, new_pc_o};
         chk_cnt++;
         if (obs !== 27'h0) $display("FAIL exc_no_stale_c%0d got=%h exp=%h", i, obs, 27'h0);
         else pass_cnt++;
      end
   endtask

   task automatic test_branch_priority;
      logic [26:0] obs;
      // Branch with only an ID stall redirects and drops the stall
      drive(1, 0, 0, 1, 16'h0100, 0);
      obs = {pause_o, flush_o, redirect_o, new_pc_o};
      chk_cnt++;
      if (obs !== {5'b00000, 5'b00110, 1'b1, 16'h0100})
         $display("FAIL br_over_id got=%h exp=%h", obs, {5'b00000, 5'b00110, 1'b1, 16'h0100});
      else pass_cnt++;
      // In BR_PEND a new branch is ignored and the ID stall is suppressed
      drive(0, 1, 0, 1, 16'h0020, 0);
      drive(1, 0, 0, 1, 16'h0030, 0);
      obs = {pause_o, flush_o, redirect_o, new_pc_o};
      chk_cnt++;
      if (obs !== {5'b00000, 5'b00110, 1'b1, 16'h0020})
         $display("FAIL pend_ignores_br got=%h exp=%h", obs, {5'b00000, 5'b00110, 1'b1, 16'h0020});
      else pass_cnt++;
      drive(0, 0, 0, 0, 16'h0000, 0);
      obs = {pause_o, flush_o, redirect_o, new_pc_o};
      chk_cnt++;
      if (obs !== 27'h0) $display("FAIL pend_done got=%h exp=%h", obs, 27'h0);
      else pass_cnt++;
   endtask

   task automatic test_watchdog;
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 0, 0, 16'h0000, 0);
         chk_cnt++;
         if (pause_o !== 5'b00111) $display("FAIL wdog_pause_c%0d got=%b exp=%b", i, pause_o, 5'b00111);
         else pass_cnt++;
         if (i == 3 || i == 4) begin
            chk_cnt++;
            if (hang_o !== (i == 4))
               $display("FAIL wdog_hang_after_%0d got=%b exp=%b", i, hang_o, (i == 4));
            else pass_cnt++;
         end
      end
      repeat (3) drive(0, 0, 0, 0, 16'h0000, 0);
      chk_cnt++;
      if (hang_o !== 1'b1) $display("FAIL wdog_sticky got=%b exp=1", hang_o);
      else pass_cnt++;
   endtask

   task automatic test_async_reset_pend;
      drive(0, 1, 0, 1, 16'h0055, 0);
      drive(0, 0, 0, 0, 16'h0000, 0);
      rst = 1'b0;
      #1;
      chk_cnt++;
      if ({redirect_o, hang_o} !== 2'b00)
         $display("FAIL async_rst got=%b exp=%b", {redirect_o, hang_o}, 2'b00);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 0, 16'h0000, 0);
         chk_cnt++;
         if ({redirect_o, new_pc_o} !== 17'h0)
            $display("FAIL post_rst_c%0d got=%h exp=%h", i, {redirect_o, new_pc_o}, 17'h0);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_mem_stall();
      test_exc_kills_pending();
      test_branch_priority();
      test_watchdog();
      test_async_reset_pend();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
